// File: rtl/score_event_gen.sv
// Score event generator for the Flappy datapath: IDLE/PLAYING/DEAD game FSM, pipe-crossing score pulse and collision detect.
// Optional build macro NO_COLLIDE_EN disables collisions (demo mode) while keeping scoring.
module score_event_gen #(
  parameter int ROWS     = 16,
  parameter int BIRD_COL = 2,
  parameter int GAP_H    = 4,
  parameter int W        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         start,
  input  logic [W-1:0] bird_row,
  input  logic [W-1:0] pipe_col,
  input  logic [W-1:0] gap_top,
  output logic         inc,
  output logic         game_over,
  output logic         playing
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DEAD    = 2'd2
  } state_t;

  localparam logic [W:0]   GAP_H_EXT = (W+1)'(GAP_H);
  localparam logic [W-1:0] BIRD_POS  = W'(BIRD_COL);

  state_t     state_q, state_d;
  logic       scored_q, scored_d;
  logic       start_q;
  logic       inc_q, inc_d;

  logic       start_rise;
  logic       at_col;
  logic       in_gap;
  logic       hit_pipe;
  logic       hit_ground;
  logic [W:0] gap_end;

  // Gap bound is widened by one bit so a gap near the ground cannot wrap.
  assign gap_end    = {1'b0, gap_top} + GAP_H_EXT;
  assign in_gap     = ({1'b0, bird_row} >= {1'b0, gap_top}) &&
                      ({1'b0, bird_row} <  gap_end);
  assign at_col     = (pipe_col == BIRD_POS);
  assign start_rise = start & ~start_q;

`ifdef NO_COLLIDE_EN
  assign hit_pipe   = 1'b0;
  assign hit_ground = 1'b0;
`else
  localparam logic [W-1:0] GROUND_ROW = W'(ROWS - 1);
  assign hit_pipe   = at_col && !in_gap;
  assign hit_ground = (bird_row >= GROUND_ROW);
`endif

  always_comb begin
    state_d  = state_q;
    scored_d = scored_q;
    inc_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d  = PLAYING;
          scored_d = 1'b0;
        end
      end
      PLAYING: begin
        // Collision wins over scoring; scored re-arms once the pipe leaves the bird column.
        if (tick) begin
          if (hit_pipe || hit_ground) begin
            state_d = DEAD;
          end else if (at_col && in_gap && !scored_q) begin
            inc_d    = 1'b1;
            scored_d = 1'b1;
          end else if (!at_col) begin
            scored_d = 1'b0;
          end
        end
      end
      DEAD: begin
        if (start_rise) begin
          state_d  = PLAYING;
          scored_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        scored_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      scored_q <= 1'b0;
      start_q  <= 1'b0;
      inc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      scored_q <= scored_d;
      start_q  <= start;
      inc_q    <= inc_d;
    end
  end

  assign inc       = inc_q;
  assign playing   = (state_q == PLAYING);
  assign game_over = (state_q == DEAD);

endmodule

// File: tb/tb_score_event_gen.sv
// Testbench for score_event_gen: directed game scenarios followed by random play, checked against a rule-level game model.
module tb_score_event_gen;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start;
  logic [3:0] bird_row;
  logic [3:0] pipe_col;
  logic [3:0] gap_top;
  logic       inc;
  logic       game_over;
  logic       playing;

  int total = 0;
  int bad   = 0;

  // Reference game model: mode 0 = waiting, 1 = in play, 2 = crashed.
  int m_mode       = 0;
  bit m_scored     = 0;
  bit m_start_prev = 0;
  bit m_inc        = 0;

  score_event_gen dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .bird_row  (bird_row),
    .pipe_col  (pipe_col),
    .gap_top   (gap_top),
    .inc       (inc),
    .game_over (game_over),
    .playing   (playing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode       = 0;
    m_scored     = 0;
    m_start_prev = 0;
    m_inc        = 0;
  endtask

  // Advance the game model by one clock using the inputs seen at this edge.
  task automatic model_step();
    int  br, pc, gt;
    bit  rise, gap_ok, crash;
    br     = int'(bird_row);
    pc     = int'(pipe_col);
    gt     = int'(gap_top);
    rise   = start && !m_start_prev;
    m_start_prev = start;
    m_inc  = 0;
    gap_ok = (br >= gt) && (br < gt + 4);
`ifdef NO_COLLIDE_EN
    crash  = 0;
`else
    crash  = (pc == 2 && !gap_ok) || (br >= 15);
`endif
    if (m_mode == 1) begin
      if (tick) begin
        if (crash) m_mode = 2;
        else if (pc == 2 && gap_ok && !m_scored) begin
          m_inc    = 1;
          m_scored = 1;
        end else if (pc != 2) m_scored = 0;
      end
    end else if (rise) begin
      m_mode   = 1;
      m_scored = 0;
    end
  endtask

  task automatic check_output(input string tag);
    check_bit({tag, ".playing"},   playing,   m_mode == 1);
    check_bit({tag, ".game_over"}, game_over, m_mode == 2);
    check_bit({tag, ".inc"},       inc,       m_inc);
    check_bit({tag, ".excl"},      inc & game_over, 1'b0);
  endtask

  task automatic apply_stimulus(input string tag, input logic t, input logic s,
                                input logic [3:0] br, input logic [3:0] pc,
                                input logic [3:0] gt);
    tick     = t;
    start    = s;
    bird_row = br;
    pipe_col = pc;
    gap_top  = gt;
    @(posedge clk);
    model_step();
    #1;
    check_output(tag);
  endtask

  initial begin
    reset    = 1'b0;
    tick     = 1'b0;
    start    = 1'b0;
    bird_row = 4'd5;
    pipe_col = 4'd9;
    gap_top  = 4'd4;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_state");
    @(negedge clk);
    reset = 1'b1;

    apply_stimulus("idle_tick",  1, 0, 5, 2, 4);
    apply_stimulus("start_rise", 0, 1, 5, 9, 4);
    apply_stimulus("tick_gap",   1, 1, 5, 2, 4);
    apply_stimulus("inc_pulse",  0, 0, 5, 2, 4);
    apply_stimulus("inc_clear",  0, 0, 5, 2, 4);
    for (int i = 0; i < 3; i++) apply_stimulus("hold_col", 1, 0, 5, 2, 4);
    apply_stimulus("col_off",    1, 0, 5, 1, 4);
    apply_stimulus("col_back",   1, 0, 5, 2, 4);
    apply_stimulus("inc_again",  0, 0, 5, 2, 4);

    // Asynchronous reset in mid-game must clear outputs before any clock edge.
    apply_stimulus("pre_reset",  1, 0, 5, 1, 4);
    #2;
    reset = 1'b0;
    #1;
    check_bit("async.playing",   playing,   1'b0);
    check_bit("async.game_over", game_over, 1'b0);
    check_bit("async.inc",       inc,       1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus("post_reset_tick", 1, 0, 5, 2, 4);
    apply_stimulus("post_reset_idle", 0, 0, 5, 2, 4);

    apply_stimulus("start2",      0, 1, 5, 9, 4);
    apply_stimulus("pipe_hit",    1, 0, 8, 2, 4);
    for (int i = 0; i < 3; i++) apply_stimulus("dead_ticks", 1, 0, 8, 2, 4);

    apply_stimulus("start3",      0, 1, 5, 9, 4);
    apply_stimulus("ground_hit",  1, 1, 15, 9, 4);
    for (int i = 0; i < 3; i++) apply_stimulus("start_held", 1, 1, 15, 9, 4);
    apply_stimulus("start_low",   0, 0, 5, 9, 4);
    apply_stimulus("restart",     0, 1, 5, 9, 4);

    apply_stimulus("gap_hi",      1, 0, 14, 2, 13);
    apply_stimulus("gap_hi_off",  1, 0, 14, 1, 13);
    apply_stimulus("gap_edge_in", 1, 0, 4, 2, 4);
    apply_stimulus("gap_edge_off",1, 0, 4, 1, 4);
    apply_stimulus("gap_edge_out",1, 0, 3, 2, 4);
    apply_stimulus("settle",      0, 0, 3, 9, 4);

    apply_stimulus("rst_start_lo",0, 0, 5, 9, 4);
    apply_stimulus("rst_start_hi",0, 1, 5, 9, 4);
    apply_stimulus("nc_ground",   1, 0, 15, 9, 4);
    apply_stimulus("nc_outgap",   1, 0, 0, 2, 4);
    apply_stimulus("nc_off",      1, 0, 5, 1, 4);
    apply_stimulus("nc_ingap",    1, 0, 5, 2, 4);
    apply_stimulus("nc_after",    0, 0, 5, 2, 4);

    for (int i = 0; i < 600; i++) begin
      apply_stimulus("random",
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 5) == 0),
                     4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 3)),
                     4'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
